// File: rtl/issue_scheduler_pkg.sv
// Shared architecture definitions for the issue stage: state encodings, NOP word,
// instruction field ranges and register address width.
package issue_scheduler_pkg;

    localparam int unsigned ARCH_REG_ADDR_W = 5;
    localparam logic [31:0] NOP_WORD        = 32'h0;

    localparam int unsigned INSTR_TYPE_MSB  = 31;
    localparam int unsigned INSTR_TYPE_LSB  = 27;
    localparam int unsigned INSTR_DST_MSB   = 16;
    localparam int unsigned INSTR_DST_LSB   = 12;

    localparam logic ISSUE_RUN       = 1'b0;
    localparam logic ISSUE_JUMP_WAIT = 1'b1;

    typedef enum logic {
        StRun      = ISSUE_RUN,
        StJumpWait = ISSUE_JUMP_WAIT
    } issue_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// In-flight destination tracker: one slot per stage after decode, shifted every cycle,
// with two combinational lookup ports.
module issue_scoreboard
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = ARCH_REG_ADDR_W,
    parameter int unsigned DEPTH      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_v,
    input  logic [REG_ADDR_W-1:0] shift_dst,
    input  logic [REG_ADDR_W-1:0] lookup0,
    input  logic [REG_ADDR_W-1:0] lookup1,
    output logic                  match0,
    output logic                  match1
);

    logic [DEPTH-1:0]      v_q;
    logic [REG_ADDR_W-1:0] dst_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) dst_q[i] <= '0;
        end else begin
            v_q[0]   <= shift_v;
            dst_q[0] <= shift_dst;
            for (int i = 1; i < int'(DEPTH); i++) begin
                v_q[i]   <= v_q[i-1];
                dst_q[i] <= dst_q[i-1];
            end
        end
    end

    // WB slot is searched too: the register file does not bypass its write port.
    always_comb begin
        match0 = 1'b0;
        match1 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (v_q[i] && dst_q[i] == lookup0) match0 = 1'b1;
            if (v_q[i] && dst_q[i] == lookup1) match1 = 1'b1;
        end
    end

endmodule

// File: rtl/issue_scheduler.sv
// Issue-stage controller: RAW stall via scoreboard, fetch freeze while a jump resolves.
// Optional perf counters under ISSUE_SCHED_PERF_EN.
module issue_scheduler
    import issue_scheduler_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = ARCH_REG_ADDR_W,
    parameter int unsigned DEPTH      = 3
`ifdef ISSUE_SCHED_PERF_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_has_dst,
    input  logic [REG_ADDR_W-1:0] issue_dst,
    input  logic                  issue_src0_used,
    input  logic [REG_ADDR_W-1:0] issue_src0,
    input  logic                  issue_src1_used,
    input  logic [REG_ADDR_W-1:0] issue_src1,
    input  logic                  issue_is_jump,
    input  logic                  jump_resolved,
    input  logic                  jump_taken,
    output logic                  fetch_en,
    output logic                  issue_en,
    output logic                  issue_clr,
    output logic                  bubble,
    output logic                  redirect
`ifdef ISSUE_SCHED_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      jump_cycles,
    output logic [CNT_W-1:0]      issued_count
`endif
);

    issue_state_e state_q, state_d;
    logic         match0, match1;
    logic         hazard, issued;

    issue_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .DEPTH      (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .shift_v   (issued & issue_has_dst),
        .shift_dst (issue_dst),
        .lookup0   (issue_src0),
        .lookup1   (issue_src1),
        .match0    (match0),
        .match1    (match1)
    );

    assign hazard = issue_valid & ((issue_src0_used & match0) | (issue_src1_used & match1));
    assign issued = (state_q == StRun) & issue_valid & ~hazard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StRun;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        fetch_en  = 1'b0;
        issue_en  = 1'b0;
        issue_clr = 1'b0;
        bubble    = 1'b0;
        redirect  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!issue_valid) begin
                    fetch_en = 1'b1;
                    issue_en = 1'b1;
                    bubble   = 1'b1;
                end else if (hazard) begin
                    bubble = 1'b1;
                end else if (issue_is_jump) begin
                    // PC already points at jump+1; freeze it and flush the issue register.
                    issue_clr = 1'b1;
                    state_d   = StJumpWait;
                end else begin
                    fetch_en = 1'b1;
                    issue_en = 1'b1;
                end
            end
            StJumpWait: begin
                bubble = 1'b1;
                if (jump_resolved) begin
                    redirect = jump_taken;
                    state_d  = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

`ifdef ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            jump_cycles  <= '0;
            issued_count <= '0;
        end else begin
            if (hazard && stall_cycles != '1)                 stall_cycles <= stall_cycles + CNT_W'(1);
            if (state_q == StJumpWait && jump_cycles != '1) jump_cycles  <= jump_cycles + CNT_W'(1);
            if (issued && issued_count != '1)               issued_count <= issued_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: per-cycle expected outputs queued with stimulus.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0, issue_has_dst = 1'b0, issue_is_jump = 1'b0;
    logic [4:0] issue_dst = '0, issue_src0 = '0, issue_src1 = '0;
    logic       issue_src0_used = 1'b0, issue_src1_used = 1'b0;
    logic       jump_resolved = 1'b0, jump_taken = 1'b0;
    logic       fetch_en, issue_en, issue_clr, bubble, redirect;
`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] stall_cycles, jump_cycles, issued_count;
    logic [31:0] base_stall, base_jump, base_issued;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  exp_q[$];
    logic [31:0] pc;
    logic [31:0] pc_j;

    localparam logic [31:0] TARGET = 32'd100;

    always #5 clk = ~clk;

    issue_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_has_dst   (issue_has_dst),
        .issue_dst       (issue_dst),
        .issue_src0_used (issue_src0_used),
        .issue_src0      (issue_src0),
        .issue_src1_used (issue_src1_used),
        .issue_src1      (issue_src1),
        .issue_is_jump   (issue_is_jump),
        .jump_resolved   (jump_resolved),
        .jump_taken      (jump_taken),
        .fetch_en        (fetch_en),
        .issue_en        (issue_en),
        .issue_clr       (issue_clr),
        .bubble          (bubble),
        .redirect        (redirect)
`ifdef ISSUE_SCHED_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .jump_cycles     (jump_cycles),
        .issued_count    (issued_count)
`endif
    );

    // Program counter as the datapath would drive it from the controller outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          pc <= '0;
        else if (redirect) pc <= TARGET;
        else if (fetch_en) pc <= pc + 32'd1;
    end

    always @(posedge clk) begin
        if (rst && jump_resolved && dut.state_q != StJumpWait)
            $error("jump_resolved driven outside jump wait");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // exp = {fetch_en, issue_en, issue_clr, bubble, redirect}
    task automatic step(input string tag, input logic r, input logic v, input logic hd,
                        input logic [4:0] d, input logic s0u, input logic [4:0] s0,
                        input logic s1u, input logic [4:0] s1, input logic j,
                        input logic jr, input logic jt, input logic [4:0] exp);
        logic [4:0] want;
        @(negedge clk);
        rst = r;
        issue_valid = v; issue_has_dst = hd; issue_dst = d;
        issue_src0_used = s0u; issue_src0 = s0;
        issue_src1_used = s1u; issue_src1 = s1;
        issue_is_jump = j; jump_resolved = jr; jump_taken = jt;
        exp_q.push_back(exp);
        #2;
        want = exp_q.pop_front();
        check(tag, {27'd0, fetch_en, issue_en, issue_clr, bubble, redirect}, {27'd0, want});
    endtask

    task automatic idle(input string tag);
        step(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11010);
    endtask

    initial begin
        // Reset: independent instruction presented while in reset
        step("reset_out", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
        check("reset_pc", pc, 32'd0);

        // Independent stream: r5<-r1,r2 ; r6<-r1,r2
        step("indep_0", 1, 1, 1, 5, 1, 1, 1, 2, 0, 0, 0, 5'b11000);
        step("indep_1", 1, 1, 1, 6, 1, 1, 1, 2, 0, 0, 0, 5'b11000);
        for (int i = 0; i < 3; i++) idle("drain_a");

        // RAW: r3<-r1,r2 then r4<-r3,r1
        step("raw_prod", 1, 1, 1, 3, 1, 1, 1, 2, 0, 0, 0, 5'b11000);
        for (int i = 0; i < 3; i++) step("raw_stall", 1, 1, 1, 4, 1, 3, 1, 1, 0, 0, 0, 5'b00010);
        step("raw_issue", 1, 1, 1, 4, 1, 3, 1, 1, 0, 0, 0, 5'b11000);
        for (int i = 0; i < 3; i++) idle("drain_b");

        // Reset mid-stall: scoreboard must be emptied at once
        step("rst_prod", 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
        step("rst_stall", 1, 1, 1, 8, 1, 7, 0, 0, 0, 0, 0, 5'b00010);
        step("rst_mid", 0, 1, 1, 8, 1, 7, 0, 0, 0, 0, 0, 5'b11000);
        step("rst_after", 1, 1, 1, 8, 1, 7, 0, 0, 0, 0, 0, 5'b11000);
        for (int i = 0; i < 3; i++) idle("drain_c");

        // Taken jump
        step("tj_issue", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00100);
        for (int i = 0; i < 2; i++) step("tj_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010);
        step("tj_resolve", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b00011);
        step("tj_run", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
        check("tj_pc", pc, TARGET);

        // Not-taken jump: PC must still hold jump+1 afterwards
        step("nj_issue", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00100);
        pc_j = pc;
        step("nj_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010);
        step("nj_resolve", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010);
        idle("nj_run");
        check("nj_pc", pc, pc_j);
`ifdef ISSUE_SCHED_PERF_EN
        base_stall  = stall_cycles;
        base_jump   = jump_cycles;
        base_issued = issued_count;
`endif

        // Jump whose condition register is still in flight
        step("hj_prod", 1, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 5'b11000);
        for (int i = 0; i < 3; i++) step("hj_stall", 1, 1, 0, 0, 1, 9, 0, 0, 1, 0, 0, 5'b00010);
        step("hj_issue", 1, 1, 0, 0, 1, 9, 0, 0, 1, 0, 0, 5'b00100);
        for (int i = 0; i < 2; i++) step("hj_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010);
        step("hj_resolve", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00010);
        idle("hj_run");
`ifdef ISSUE_SCHED_PERF_EN
        check("perf_stall", stall_cycles - base_stall, 32'd3);
        check("perf_jump", jump_cycles - base_jump, 32'd3);
        check("perf_issued", issued_count - base_issued, 32'd2);
`endif

        if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
